// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: instruction-fetch front end for the 14-bit core.
// Presents PC to the combinational program ROM, registers the returned word
// into IR, and handles GOTO/CALL/RETURN/RETLW flushes, execute skips and the
// circular hardware return stack.
// Optional feature macro: STACK_FLAG_EN (fullness count plus sticky
// overflow/underflow flags); when undefined both flags read 0.
module pic_fetch_unit #(
    parameter int unsigned STACK_DEPTH  = 8,
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    input  logic        Stall_in,
    input  logic        Skip_in,
    output logic [13:0] Instr_out,
    output logic        Instr_valid,
    output logic [10:0] Pc_out,
    output logic        Stack_ovf,
    output logic        Stack_unf
);

    localparam int unsigned PC_W = 11;
    localparam int unsigned IW   = 14;
    localparam int unsigned SP_W = $clog2(STACK_DEPTH);

    localparam logic [IW-1:0] NOP_WORD    = 14'h0000;
    localparam logic [IW-1:0] RETURN_WORD = 14'h0008;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] pop_idx;
    logic            push, pop;
    logic            is_goto, is_call, is_ret;

    // Branch decode from IR; a bubble never decodes as a branch.
    always_comb begin
        is_goto = valid_q && (ir_q[13:11] == 3'b101);
        is_call = valid_q && (ir_q[13:11] == 3'b100);
        is_ret  = valid_q && ((ir_q == RETURN_WORD) || (ir_q[13:10] == 4'b1101));
        pop_idx = sp_q - SP_W'(1);
    end

    // Next-state selection in branch > skip > fetch priority; stall freezes all.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (!Stall_in) begin
            if (is_goto) begin
                pc_d    = ir_q[PC_W-1:0];
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else if (is_call) begin
                push    = 1'b1;
                pc_d    = ir_q[PC_W-1:0];
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else if (is_ret) begin
                pop     = 1'b1;
                pc_d    = stack_q[pop_idx];
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else if (Skip_in) begin
                pc_d    = pc_q + PC_W'(1);
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else begin
                ir_d     = Rom_data_in;
                pc_out_d = pc_q;
                pc_d     = pc_q + PC_W'(1);
                valid_d  = 1'b1;
            end
        end
    end

    // Pipeline registers and return stack; PC at push time already points past the CALL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_VECTOR;
            ir_q     <= NOP_WORD;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            sp_q     <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            if (push) begin
                stack_q[sp_q] <= pc_q;
                sp_q          <= sp_q + SP_W'(1);
            end else if (pop) begin
                sp_q <= pop_idx;
            end
        end
    end

`ifdef STACK_FLAG_EN
    localparam int unsigned CNT_W = SP_W + 1;

    logic [CNT_W-1:0] count_q;
    logic             ovf_q, unf_q;

    // Fullness count with sticky overflow/underflow; pointer wrap itself is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (push) begin
            if (count_q == CNT_W'(STACK_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (count_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign Stack_ovf = ovf_q;
    assign Stack_unf = unf_q;
`else
    assign Stack_ovf = 1'b0;
    assign Stack_unf = 1'b0;
`endif

    assign Rom_addr_out = pc_q;
    assign Instr_out    = ir_q;
    assign Instr_valid  = valid_q;
    assign Pc_out       = pc_out_q;

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Bench for pic_fetch_unit: behavioural fetch model checked every cycle,
// plus directed programs with literal expectations.
module tb_pic_fetch_unit;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [10:0] Rom_addr_out;
    logic [13:0] Rom_data_in;
    logic        Stall_in;
    logic        Skip_in;
    logic [13:0] Instr_out;
    logic        Instr_valid;
    logic [10:0] Pc_out;
    logic        Stack_ovf;
    logic        Stack_unf;

    logic [13:0] rom [0:2047];

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int m_pc, m_pcout, m_ir, m_valid;
    int m_stk [0:DEPTH-1];
    int m_sp, m_cnt, m_ovf, m_unf;

    pic_fetch_unit #(.STACK_DEPTH(8), .RESET_VECTOR(11'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rom_addr_out(Rom_addr_out),
        .Rom_data_in (Rom_data_in),
        .Stall_in    (Stall_in),
        .Skip_in     (Skip_in),
        .Instr_out   (Instr_out),
        .Instr_valid (Instr_valid),
        .Pc_out      (Pc_out),
        .Stack_ovf   (Stack_ovf),
        .Stack_unf   (Stack_unf)
    );

    assign Rom_data_in = rom[Rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_pc = 0; m_pcout = 0; m_ir = 0; m_valid = 0;
        m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
    endtask

    // One clock of the architectural fetch rules.
    task automatic model_step;
        int k;
        k = m_ir % 2048;
        if (m_valid != 0 && (m_ir / 2048) == 5) begin
            m_pc = k; m_ir = 0; m_valid = 0;
        end else if (m_valid != 0 && (m_ir / 2048) == 4) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % DEPTH;
            if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
            m_pc = k; m_ir = 0; m_valid = 0;
        end else if (m_valid != 0 && (m_ir == 8 || (m_ir / 1024) == 13)) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stk[m_sp];
            if (m_cnt == 0) m_unf = 1; else m_cnt--;
            m_ir = 0; m_valid = 0;
        end else if (Skip_in) begin
            m_pc = (m_pc + 1) % 2048; m_ir = 0; m_valid = 0;
        end else begin
            m_ir = int'(rom[m_pc]); m_pcout = m_pc;
            m_pc = (m_pc + 1) % 2048; m_valid = 1;
        end
    endtask

    // Model advance: asynchronous reset, otherwise step unless stalled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (!Stall_in) model_step();
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        int e_ovf, e_unf;
`ifdef STACK_FLAG_EN
        e_ovf = m_ovf; e_unf = m_unf;
`else
        e_ovf = 0; e_unf = 0;
`endif
        check("cyc_rom_addr", int'(Rom_addr_out), m_pc);
        check("cyc_instr", int'(Instr_out), m_ir);
        check("cyc_valid", int'(Instr_valid), m_valid);
        check("cyc_pc_out", int'(Pc_out), m_pcout);
        check("cyc_ovf", int'(Stack_ovf), e_ovf);
        check("cyc_unf", int'(Stack_unf), e_unf);
    end

    task automatic wait_pc(input int target, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (Instr_valid && int'(Pc_out) == target) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("reach_%0h", target), int'(found), 1);
    endtask

    int flag_on;

    initial begin
`ifdef STACK_FLAG_EN
        flag_on = 1;
`else
        flag_on = 0;
`endif
        model_reset();
        rst_n = 1'b0; Stall_in = 1'b0; Skip_in = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
        rom[11'h000] = 14'h01A5;
        rom[11'h001] = 14'h0103;
        rom[11'h002] = 14'h3001;
        rom[11'h003] = 14'h280B;   // GOTO 0x0B
        rom[11'h00B] = 14'h0BA2;
        rom[11'h00D] = 14'h2812;   // GOTO 0x12
        rom[11'h012] = 14'h2804;   // GOTO 0x04
        rom[11'h005] = 14'h2010;   // CALL 0x10
        rom[11'h010] = 14'h0008;   // RETURN
        rom[11'h006] = 14'h2A00;   // GOTO 0x200
        // Nine nested routines: each CALLs the next, then RETURNs.
        for (int i = 0; i < 9; i++) begin
            rom[11'h200 + 11'(16 * i)]     = 14'h2000 | 14'(11'h210 + 11'(16 * i));
            rom[11'h200 + 11'(16 * i) + 1] = 14'h0008;
        end
        rom[11'h290] = 14'h0008;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr", int'(Instr_out), 0);
        check("rst_valid", int'(Instr_valid), 0);
        check("rst_pc_out", int'(Pc_out), 0);
        check("rst_rom_addr", int'(Rom_addr_out), 0);
        rst_n = 1'b1;

        // Reset fetch
        @(negedge clk);
        check("rf0_instr", int'(Instr_out), 14'h01A5);
        check("rf0_pc", int'(Pc_out), 0);
        check("rf0_valid", int'(Instr_valid), 1);
        @(negedge clk);
        check("rf1_instr", int'(Instr_out), 14'h0103);
        check("rf1_pc", int'(Pc_out), 1);
        @(negedge clk);
        check("rf2_instr", int'(Instr_out), 14'h3001);
        check("rf2_pc", int'(Pc_out), 2);

        // Skip while 0x0BA2 is in execute: 0x0C squashed
        wait_pc(11'h00B, 20);
        check("skip_instr", int'(Instr_out), 14'h0BA2);
        Skip_in = 1'b1;
        @(negedge clk);
        Skip_in = 1'b0;
        check("skip_bubble", int'(Instr_valid), 0);
        check("skip_addr", int'(Rom_addr_out), 11'h00D);
        @(negedge clk);
        check("skip_next_pc", int'(Pc_out), 11'h00D);
        check("skip_next_valid", int'(Instr_valid), 1);

        // GOTO 0x04 from 0x12
        wait_pc(11'h012, 20);
        @(negedge clk);
        check("goto_bubble", int'(Instr_valid), 0);
        @(negedge clk);
        check("goto_pc", int'(Pc_out), 11'h004);
        check("goto_instr", int'(Instr_out), 0);
        check("goto_valid", int'(Instr_valid), 1);

        // CALL 0x10 / RETURN to 0x006
        wait_pc(11'h005, 20);
        @(negedge clk);
        check("call_bubble", int'(Instr_valid), 0);
        @(negedge clk);
        check("call_pc", int'(Pc_out), 11'h010);
        @(negedge clk);
        check("ret_bubble", int'(Instr_valid), 0);
        @(negedge clk);
        check("ret_pc", int'(Pc_out), 11'h006);
        check("ret_valid", int'(Instr_valid), 1);

        // Nine nested CALLs overflow the 8-entry stack
        wait_pc(11'h290, 100);
        check("ovf_after_9", int'(Stack_ovf), flag_on);
        check("unf_before", int'(Stack_unf), 0);
        // Eighth RETURN lands on the 2nd-pushed address, no underflow yet
        wait_pc(11'h211, 100);
        check("unf_at_2nd", int'(Stack_unf), 0);
        // Ninth RETURN pops the wrapped slot and underflows
        wait_pc(11'h281, 20);
        check("unf_after_9", int'(Stack_unf), flag_on);
        check("ovf_sticky", int'(Stack_ovf), flag_on);

        // Reset asserted mid-operation clears immediately
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(Instr_valid), 0);
        check("mid_rst_instr", int'(Instr_out), 0);
        check("mid_rst_pc_out", int'(Pc_out), 0);
        check("mid_rst_addr", int'(Rom_addr_out), 0);
        check("mid_rst_ovf", int'(Stack_ovf), 0);
        check("mid_rst_unf", int'(Stack_unf), 0);
        rom[11'h010] = 14'h345A;   // RETLW 0x5A
        @(negedge clk);
        rst_n = 1'b1;

        // Stall for 3 cycles holds IR, Pc_out and ROM address
        wait_pc(11'h002, 10);
        Stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_instr", int'(Instr_out), 14'h3001);
            check("stall_pc", int'(Pc_out), 2);
            check("stall_addr", int'(Rom_addr_out), 3);
        end
        Stall_in = 1'b0;

        // CALL 0x10 / RETLW back to 0x006
        wait_pc(11'h005, 40);
        @(negedge clk);
        check("retlw_call_bubble", int'(Instr_valid), 0);
        @(negedge clk);
        check("retlw_pc", int'(Pc_out), 11'h010);
        check("retlw_instr", int'(Instr_out), 14'h345A);
        @(negedge clk);
        check("retlw_bubble", int'(Instr_valid), 0);
        @(negedge clk);
        check("retlw_ret_pc", int'(Pc_out), 11'h006);
        check("retlw_flags", int'(Stack_ovf) + int'(Stack_unf), 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, got hang expected finish");
        $fatal(1);
    end

endmodule
